bus_interconnect: RTL and testbench
===================================

Name: bus_interconnect

Overview:
- Parametrised single-master, N-slave bus fabric. It replaces the hand-written, fixed-range read-data mux at SoC top level.
- Takes core load/store requests and decodes them against per-slave base/mask windows. It drives a one-hot slave select, waits for a slave acknowledge, and returns steered read data.
- Adds what the fixed mux lacks: wait states, an unmapped-address error, a slave timeout error and an error counter.

Parameters:
- N_SLAVES, 4, number of slave ports (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- SLV_BASE, {N_SLAVES{ADDR_W'h0}}, packed base addresses; slave i occupies bits [i*ADDR_W +: ADDR_W].
- SLV_MASK, {N_SLAVES{ADDR_W'h0}}, packed decode masks; slave i matches when (addr & mask_i) == base_i.
- TIMEOUT, 16, maximum cycles spent waiting for a slave ack (>=1).
- ERRCNT_W, 8, width of the error counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- m_req_i  in  1  master request valid.
- m_we_i  in  1  1 = write, 0 = read.
- m_addr_i  in  ADDR_W  byte address.
- m_wdata_i  in  DATA_W  write data.
- m_ready_o  out  1  request accepted this cycle (high only in IDLE).
- m_rvalid_o  out  1  one-cycle completion pulse, for reads and writes.
- m_rdata_o  out  DATA_W  read data, valid with m_rvalid_o.
- m_err_o  out  1  error flag, valid with m_rvalid_o.
- s_sel_o  out  N_SLAVES  one-hot slave select, held for the whole access.
- s_we_o  out  1  latched write enable.
- s_addr_o  out  ADDR_W  latched full address.
- s_wdata_o  out  DATA_W  latched write data.
- s_ack_i  in  N_SLAVES  per-slave acknowledge (read data valid / write done).
- s_rdata_i  in  N_SLAVES*DATA_W  packed slave read data.
- err_cnt_o  out  ERRCNT_W  saturating count of error completions.

Behaviour:
- Reset values:
  - state = IDLE.
  - m_rvalid_o = 0, m_rdata_o = 0, m_err_o = 0.
  - s_sel_o = 0, s_we_o = 0, s_addr_o = 0, s_wdata_o = 0.
  - err_cnt_o = 0.
  - Timeout counter = 0.
- FSM states: IDLE, ACCESS, ERR.
- m_ready_o = (state == IDLE). This is combinational, but the block has no other input-to-output combinational paths.
- IDLE, when m_req_i = 1:
  - Latch we, addr and wdata into the s_* registers.
  - Decode the address; the lowest-index matching slave wins, so overlapping windows are legal.
  - Match: s_sel_o <= onehot(idx), counter <= 0, next state ACCESS.
  - No match: s_sel_o stays 0, next state ERR.
- ERR (one cycle):
  - m_rvalid_o = 1, m_err_o = 1, m_rdata_o = 0.
  - err_cnt_o increments.
  - Next state IDLE.
- ACCESS:
  - If s_ack_i[idx] = 1: register m_rdata_o <= s_rdata_i[idx] (0 for writes), m_err_o <= 0. Pulse m_rvalid_o next cycle, clear s_sel_o, go to IDLE.
  - Otherwise the counter increments. If the counter reaches TIMEOUT-1 without ack: clear s_sel_o, respond next cycle with m_err_o = 1 and m_rdata_o = 0, increment err_cnt_o, go to IDLE.
  - An ack arriving in the final (TIMEOUT-th) cycle wins over the timeout.
- Latency, request accepted at cycle 0:
  - s_sel_o high from cycle 1.
  - Zero-wait slave (ack at cycle 1): m_rvalid_o at cycle 2.
  - Unmapped address: m_rvalid_o at cycle 1.
  - Timeout: m_rvalid_o at cycle TIMEOUT+1.
- Acks are ignored outside ACCESS, and acks from non-selected slaves are always ignored.
- m_req_i is ignored outside IDLE; the master must hold its request until m_ready_o.
- err_cnt_o saturates at all-ones.
- Back-to-back: a new request can be accepted in the same cycle m_rvalid_o pulses, because the FSM is back in IDLE. Throughput is therefore one access per 2 cycles for zero-wait slaves.
- Reset asserted mid-access: all state returns to reset values at the next edge. No m_rvalid_o is produced for the aborted access, and s_sel_o drops immediately.

Decomposition:
- Shared defines header holds:
  - bus width macros (data_bus, mem_addr_bus widths);
  - default SoC memory-map bases and masks for memory, tim and uart;
  - FSM state encodings: IDLE = 2'd0, ACCESS = 2'd1, ERR = 2'd2.
- One sub-module, bus_addr_decoder: purely combinational, parametrised. It outputs the match flag and a priority-encoded index from addr, SLV_BASE and SLV_MASK.

Test Plan:
- Setup for all scenarios: N = 3; bases 0x0000 / 0x1000 / 0x2000; mask 0xF000; TIMEOUT = 4.
- Zero-wait read: read 0x1004 with slave1 acking at cycle 1 and rdata 0xDEADBEEF -> s_sel_o = 3'b010 at cycle 1; m_rvalid_o = 1, m_rdata_o = 0xDEADBEEF, m_err_o = 0 at cycle 2.
- Wait states plus write: write 0x0008, data 0x55, slave0 acks at cycle 3 -> s_we_o = 1 and s_wdata_o = 0x55 held during cycles 1-3; m_rvalid_o at cycle 4, m_err_o = 0.
- Unmapped: read 0x5000 -> s_sel_o stays 0; m_rvalid_o = 1, m_err_o = 1, m_rdata_o = 0 at cycle 1; err_cnt_o = 1.
- Timeout: read 0x2000 with slave2 never acking -> s_sel_o high during cycles 1-4; m_err_o pulse at cycle 5; err_cnt_o increments. A repeat run with ack at cycle 4 gives m_err_o = 0.
- Corner: overlapping windows (slave1 base 0x0000, mask 0x0000) pick slave0; reset asserted at cycle 2 of a waiting access -> s_sel_o = 0 and no m_rvalid_o pulse; 300 errors -> err_cnt_o = 255.

Source files
------------

// File: rtl/bus_interconnect_pkg.sv
// Shared definitions for the single-master bus fabric: bus widths, default SoC
// memory map and FSM state encodings.
package bus_interconnect_pkg;

  localparam int DATA_BUS_W     = 32;
  localparam int MEM_ADDR_BUS_W = 32;

  // Default SoC memory map: 4 KiB windows for memory, timer and uart
  localparam logic [MEM_ADDR_BUS_W-1:0] MEM_BASE  = 32'h0000_0000;
  localparam logic [MEM_ADDR_BUS_W-1:0] MEM_MASK  = 32'h0000_F000;
  localparam logic [MEM_ADDR_BUS_W-1:0] TIM_BASE  = 32'h0000_1000;
  localparam logic [MEM_ADDR_BUS_W-1:0] TIM_MASK  = 32'h0000_F000;
  localparam logic [MEM_ADDR_BUS_W-1:0] UART_BASE = 32'h0000_2000;
  localparam logic [MEM_ADDR_BUS_W-1:0] UART_MASK = 32'h0000_F000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } state_t;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    onehot16 = 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational base/mask address decoder; the lowest-index matching window
// wins so overlapping windows are legal.
module bus_addr_decoder #(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W   = 32,
  parameter int IDX_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  // Walk from the top down so the lowest matching index is the last writer
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_interconnect.sv
// Single-master, N-slave bus fabric: decodes, selects one slave, waits for its
// ack with a timeout, and returns steered read data or an error response.
module bus_interconnect
  import bus_interconnect_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = '0,
  parameter int TIMEOUT  = 16,
  parameter int ERRCNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_req_i,
  input  logic                       m_we_i,
  input  logic [ADDR_W-1:0]          m_addr_i,
  input  logic [DATA_W-1:0]          m_wdata_i,
  output logic                       m_ready_o,
  output logic                       m_rvalid_o,
  output logic [DATA_W-1:0]          m_rdata_o,
  output logic                       m_err_o,
  output logic [N_SLAVES-1:0]        s_sel_o,
  output logic                       s_we_o,
  output logic [ADDR_W-1:0]          s_addr_o,
  output logic [DATA_W-1:0]          s_wdata_o,
  input  logic [N_SLAVES-1:0]        s_ack_i,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata_i,
  output logic [ERRCNT_W-1:0]        err_cnt_o
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt;
  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  bus_addr_decoder #(
    .N_SLAVES (N_SLAVES),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .addr (m_addr_i),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  assign m_ready_o = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx_q      <= '0;
      cnt        <= '0;
      m_rvalid_o <= 1'b0;
      m_rdata_o  <= '0;
      m_err_o    <= 1'b0;
      s_sel_o    <= '0;
      s_we_o     <= 1'b0;
      s_addr_o   <= '0;
      s_wdata_o  <= '0;
      err_cnt_o  <= '0;
    end else begin
      m_rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (m_req_i) begin
            s_we_o    <= m_we_i;
            s_addr_o  <= m_addr_i;
            s_wdata_o <= m_wdata_i;
            if (dec_hit) begin
              s_sel_o <= N_SLAVES'(onehot16(4'(dec_idx)));
              idx_q   <= dec_idx;
              cnt     <= '0;
              state   <= ACCESS;
            end else begin
              // Unmapped: the error response is visible during the ERR cycle
              m_rvalid_o <= 1'b1;
              m_err_o    <= 1'b1;
              m_rdata_o  <= '0;
              err_cnt_o  <= sat_inc(err_cnt_o);
              state      <= ERR;
            end
          end
        end
        ACCESS: begin
          if (s_ack_i[idx_q]) begin
            m_rvalid_o <= 1'b1;
            m_err_o    <= 1'b0;
            m_rdata_o  <= s_we_o ? '0 : s_rdata_i[idx_q*DATA_W +: DATA_W];
            s_sel_o    <= '0;
            state      <= IDLE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            m_rvalid_o <= 1'b1;
            m_err_o    <= 1'b1;
            m_rdata_o  <= '0;
            err_cnt_o  <= sat_inc(err_cnt_o);
            s_sel_o    <= '0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_interconnect.sv
// Scoreboard bench for bus_interconnect: 3 slaves on 4 KiB windows, TIMEOUT 4.
module tb_bus_interconnect;
  import bus_interconnect_pkg::*;

  localparam int N  = 3;
  localparam int AW = MEM_ADDR_BUS_W;
  localparam int DW = DATA_BUS_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ready, m_rvalid, m_err;
  logic [DW-1:0] m_rdata;
  logic [N-1:0]  s_sel, s_ack;
  logic          s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [N*DW-1:0] s_rdata;
  logic [7:0]    err_cnt;

  logic          req2, we2, ready2, rvalid2, err2, swe2;
  logic [AW-1:0] addr2, saddr2;
  logic [DW-1:0] wdata2, rdata2, swdata2;
  logic [N-1:0]  sel2, ack2;
  logic [N*DW-1:0] srdata2;
  logic [7:0]    errcnt2;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   exp_errs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_interconnect #(
    .N_SLAVES (N), .ADDR_W (AW), .DATA_W (DW),
    .SLV_BASE ({UART_BASE, TIM_BASE, MEM_BASE}),
    .SLV_MASK ({UART_MASK, TIM_MASK, MEM_MASK}),
    .TIMEOUT (4), .ERRCNT_W (8)
  ) dut (
    .clk (clk), .rst (rst), .m_req_i (m_req), .m_we_i (m_we), .m_addr_i (m_addr),
    .m_wdata_i (m_wdata), .m_ready_o (m_ready), .m_rvalid_o (m_rvalid),
    .m_rdata_o (m_rdata), .m_err_o (m_err), .s_sel_o (s_sel), .s_we_o (s_we),
    .s_addr_o (s_addr), .s_wdata_o (s_wdata), .s_ack_i (s_ack),
    .s_rdata_i (s_rdata), .err_cnt_o (err_cnt)
  );

  // Overlapping map: slave1 (mask 0) covers everything, slave0 must still win
  bus_interconnect #(
    .N_SLAVES (N), .ADDR_W (AW), .DATA_W (DW),
    .SLV_BASE ({32'h0000_2000, 32'h0000_0000, 32'h0000_0000}),
    .SLV_MASK ({32'h0000_F000, 32'h0000_0000, 32'h0000_F000}),
    .TIMEOUT (4), .ERRCNT_W (8)
  ) dut2 (
    .clk (clk), .rst (rst), .m_req_i (req2), .m_we_i (we2), .m_addr_i (addr2),
    .m_wdata_i (wdata2), .m_ready_o (ready2), .m_rvalid_o (rvalid2),
    .m_rdata_o (rdata2), .m_err_o (err2), .s_sel_o (sel2), .s_we_o (swe2),
    .s_addr_o (saddr2), .s_wdata_o (swdata2), .s_ack_i (ack2),
    .s_rdata_i (srdata2), .err_cnt_o (errcnt2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse must match the oldest expected response
  always @(negedge clk) begin
    if (m_rvalid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rvalid_unexpected: got pulse at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rdata", m_rdata, e.rdata);
        chk("err", m_err, e.err);
        chk("rvalid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int ack_at, input logic [N-1:0] exp_sel, input logic [N-1:0] noise,
                        input logic [DW-1:0] ack_data, input logic [DW-1:0] exp_rdata,
                        input logic exp_err, input int lat);
    @(posedge clk); #1;
    m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata;
    chk("ready", m_ready, 1);
    exp_q.push_back('{exp_rdata, exp_err, cyc + lat});
    if (exp_err) exp_errs = (exp_errs == 255) ? 255 : exp_errs + 1;
    @(posedge clk); #1;
    m_req = 1'b0;
    for (int c = 1; c < lat; c++) begin
      chk("s_sel", s_sel, exp_sel);
      chk("s_we", s_we, we);
      chk("s_addr", s_addr, addr);
      if (we) chk("s_wdata", s_wdata, wdata);
      s_rdata = {32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};
      for (int i = 0; i < N; i++) if (exp_sel[i]) s_rdata[i*DW +: DW] = ack_data;
      s_ack = noise & ~exp_sel;
      if (c == ack_at) s_ack = s_ack | exp_sel;
      @(posedge clk); #1;
    end
    s_ack = '0;
    chk("s_sel_idle", s_sel, 0);
    chk("err_cnt", err_cnt, exp_errs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    s_ack = '0; s_rdata = '0;
    req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0; ack2 = '0;
    srdata2 = {32'h2222_2222, 32'h1111_1111, 32'hA5A5_A5A5};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", m_rvalid, 0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_err", m_err, 0);
    chk("rst_sel", s_sel, 0);
    chk("rst_we", s_we, 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_wdata", s_wdata, 0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_ready", m_ready, 1);
    rst = 1'b0;

    // zero-wait read from slave1
    access(1'b0, 32'h1004, 32'h0, 1, 3'b010, 3'b000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2);
    // write to slave0 with two wait states; write completions return 0
    access(1'b1, 32'h0008, 32'h55, 3, 3'b001, 3'b000, 32'h77, 32'h0, 1'b0, 4);
    // unmapped
    access(1'b0, 32'h5000, 32'h0, -1, 3'b000, 3'b000, 32'h0, 32'h0, 1'b1, 1);
    // timeout on slave2
    access(1'b0, 32'h2000, 32'h0, -1, 3'b100, 3'b000, 32'h0, 32'h0, 1'b1, 5);
    // ack in the final cycle beats the timeout
    access(1'b0, 32'h2000, 32'h0, 4, 3'b100, 3'b000, 32'h1234_5678, 32'h1234_5678, 1'b0, 5);
    // acks from non-selected slaves are ignored
    access(1'b0, 32'h1000, 32'h0, 2, 3'b010, 3'b101, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 3);

    // overlapping windows on dut2
    @(posedge clk); #1;
    req2 = 1'b1; addr2 = 32'h0000_0010;
    chk("ovl_ready", ready2, 1);
    @(posedge clk); #1;
    req2 = 1'b0;
    chk("ovl_sel", sel2, 3'b001);
    chk("ovl_addr", saddr2, 32'h10);
    chk("ovl_we", swe2, 0);
    ack2 = 3'b011;
    @(posedge clk); #1;
    ack2 = '0;
    chk("ovl_rvalid", rvalid2, 1);
    chk("ovl_rdata", rdata2, 32'hA5A5_A5A5);
    chk("ovl_err", err2, 0);
    chk("ovl_sel_idle", sel2, 0);
    chk("ovl_errcnt", errcnt2, 0);
    chk("ovl_wdata", swdata2, 0);

    // reset during a waiting access: no completion, select dropped
    @(posedge clk); #1;
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h2000;
    @(posedge clk); #1;
    m_req = 1'b0;
    chk("abort_sel_c1", s_sel, 3'b100);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_sel", s_sel, 0);
    chk("abort_errcnt", err_cnt, 0);
    chk("abort_ready", m_ready, 1);
    rst = 1'b0;
    exp_errs = 0;
    repeat (6) @(posedge clk);

    // saturate the error counter
    for (int k = 0; k < 300; k++)
      access(1'b0, 32'h7000, 32'h0, -1, 3'b000, 3'b000, 32'h0, 32'h0, 1'b1, 1);
    chk("errcnt_sat", err_cnt, 8'd255);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
